// File: rtl/wb_cdb_arbiter.sv
// wb_cdb_arbiter: round-robin writeback arbiter sharing one registered CDB write port
// among the ALU, MUL, DIV and LOAD result buffers.
module wb_cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mul_valid,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [DATA_W-1:0] mul_data,
    output logic              mul_ready,
    input  logic              div_valid,
    input  logic [TAG_W-1:0]  div_tag,
    input  logic [DATA_W-1:0] div_data,
    output logic              div_ready,
    input  logic              ld_valid,
    input  logic [TAG_W-1:0]  ld_tag,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic [1:0]        cdb_src,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  conflict_cnt
);
    logic [3:0]        src_valid, rdy, acc, gnt, buf_v;
    logic [TAG_W-1:0]  src_tag [4];
    logic [TAG_W-1:0]  buf_tag [4];
    logic [DATA_W-1:0] src_data [4];
    logic [DATA_W-1:0] buf_data [4];
    logic [1:0]        rr_ptr, gnt_idx, j;
    logic              any, multi;

    assign src_valid = {ld_valid, div_valid, mul_valid, alu_valid};
    assign src_tag   = '{alu_tag, mul_tag, div_tag, ld_tag};
    assign src_data  = '{alu_data, mul_data, div_data, ld_data};

    // Walk the search order backwards so the earliest hit (closest to rr_ptr) wins.
    always_comb begin
        any     = 1'b0;
        gnt_idx = rr_ptr;
        j       = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            j = rr_ptr + 2'(i);
            if (buf_v[j]) begin
                any     = 1'b1;
                gnt_idx = j;
            end
        end
    end

    assign gnt   = any ? (4'b0001 << gnt_idx) : 4'b0000;
    assign rdy   = flush ? 4'b0000 : (~buf_v | gnt);
    assign acc   = src_valid & rdy;
    assign multi = (buf_v & (buf_v - 4'd1)) != 4'd0;
    assign {ld_ready, div_ready, mul_ready, alu_ready} = rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v     <= 4'b0000;
            rr_ptr    <= 2'd0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= 2'd0;
        end else if (flush) begin
            buf_v     <= 4'b0000;
            cdb_valid <= 1'b0;
        end else begin
            buf_v     <= (buf_v & ~gnt) | acc;
            cdb_valid <= any;
            if (any) begin
                cdb_tag  <= buf_tag[gnt_idx];
                cdb_data <= buf_data[gnt_idx];
                cdb_src  <= gnt_idx;
                rr_ptr   <= gnt_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (cnt_clr)
            conflict_cnt <= '0;
        else if (!flush && multi && !(&conflict_cnt))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
    end

    // Payload needs no reset: buf_v qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                buf_tag[i]  <= src_tag[i];
                buf_data[i] <= src_data[i];
            end
        end
    end
endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// tb_wb_cdb_arbiter: scenario tasks drive the arbiter; a CDB monitor pops an
// expected-write queue filled in grant order as stimulus is applied.
module tb_wb_cdb_arbiter;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [1:0]        src;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk, rst_n, flush, cnt_clr;
    logic [3:0] sv;
    logic [3:0] sr;
    logic [TAG_W-1:0]  st [4];
    logic [DATA_W-1:0] sd [4];
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [1:0]        cdb_src;
    logic [CNT_W-1:0]  conflict_cnt;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   free_run = 0;

    wb_cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alu_valid(sv[0]), .alu_tag(st[0]), .alu_data(sd[0]), .alu_ready(sr[0]),
        .mul_valid(sv[1]), .mul_tag(st[1]), .mul_data(sd[1]), .mul_ready(sr[1]),
        .div_valid(sv[2]), .div_tag(st[2]), .div_data(sd[2]), .div_ready(sr[2]),
        .ld_valid(sv[3]),  .ld_tag(st[3]),  .ld_data(sd[3]),  .ld_ready(sr[3]),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cdb_valid && !free_run) begin
            ent_t e;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL cdb_unexpected: got src=%0d tag=%0d data=%h, required no write", cdb_src, cdb_tag, cdb_data);
            end else begin
                e = q.pop_front();
                if ({cdb_src, cdb_tag, cdb_data} !== e) begin
                    fails++;
                    $display("FAIL cdb_write: got src=%0d tag=%0d data=%h, required src=%0d tag=%0d data=%h",
                             cdb_src, cdb_tag, cdb_data, e.src, e.tag, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        sv[s] = 1'b1;
        st[s] = t;
        sd[s] = d;
        q.push_back({2'(s), t, d});
    endtask

    task automatic do_reset();
        rst_n = 0; sv = 4'b0; flush = 0; cnt_clr = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; sv = 4'b0; flush = 0; cnt_clr = 0;
        for (int i = 0; i < 4; i++) begin st[i] = '0; sd[i] = '0; end
        #1;
        tests++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b tag=%0d data=%h src=%0d cnt=%0d, required all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src, conflict_cnt);
        end
        tick();
        rst_n = 1;
        tick();
        tests++;
        if (sr !== 4'b1111) begin fails++; $display("FAIL reset_ready: got %b required 1111", sr); end
        sv[0] = 1; st[0] = 5'd9; sd[0] = 32'h1234;
        tick();
        sv[0] = 0;
        rst_n = 0;
        #1;
        tick();
        rst_n = 1;
        tick();
        tests++;
        if (cdb_valid !== 1'b0 || sr !== 4'b1111) begin
            fails++;
            $display("FAIL reset_midop: got valid=%b ready=%b, required 0 1111", cdb_valid, sr);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(0, 5'd5, 32'hDEADBEEF);
        tests++;
        if (sr[0] !== 1'b1) begin fails++; $display("FAIL single_ready: got %b required 1", sr[0]); end
        tick();
        sv[0] = 0;
        tests++;
        if (cdb_valid !== 1'b0) begin fails++; $display("FAIL single_early: got %b required 0", cdb_valid); end
        tick();
        tests++;
        if (cdb_valid !== 1'b1) begin fails++; $display("FAIL single_latency: got %b required 1", cdb_valid); end
        tick();
        tests++;
        if (cdb_valid !== 1'b0) begin fails++; $display("FAIL single_oneshot: got %b required 0", cdb_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int s = 0; s < 4; s++) drive(s, 5'(s + 1), 32'hA000_0000 + 32'(s));
        tick();
        sv = 4'b0;
        tests++;
        if (sr[1] !== 1'b0) begin fails++; $display("FAIL sim_mul_ready: got %b required 0", sr[1]); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (cdb_valid !== 1'b1 || cdb_src !== 2'(i)) begin
                fails++;
                $display("FAIL sim_order: slot %0d got valid=%b src=%0d, required 1 %0d", i, cdb_valid, cdb_src, i);
            end
        end
        tick();
        tests++;
        if (conflict_cnt !== 16'd3) begin fails++; $display("FAIL sim_conflicts: got %0d required 3", conflict_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, 5'(i), $urandom);
            tests++;
            if (sr[0] !== 1'b1) begin fails++; $display("FAIL b2b_ready: beat %0d got %b required 1", i, sr[0]); end
            tick();
            if (i > 0) begin
                tests++;
                if (cdb_valid !== 1'b1) begin fails++; $display("FAIL b2b_bubble: beat %0d got %b required 1", i, cdb_valid); end
            end
        end
        sv[0] = 0;
        tick();
        tests++;
        if (cdb_valid !== 1'b1) begin fails++; $display("FAIL b2b_last: got %b required 1", cdb_valid); end
        tick();
        tests++;
        if (cdb_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b required 0", cdb_valid); end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        drive(2, 5'd9, 32'h9);
        tick(); sv = 4'b0; tick(); tick();
        drive(3, 5'd10, 32'h10);
        drive(0, 5'd11, 32'h11);
        tick(); sv = 4'b0;
        tick();
        tests++;
        if (cdb_src !== 2'd3) begin fails++; $display("FAIL rr_wrap_ld: got %0d required 3", cdb_src); end
        tick();
        tests++;
        if (cdb_src !== 2'd0) begin fails++; $display("FAIL rr_wrap_alu: got %0d required 0", cdb_src); end
        drive(1, 5'd13, 32'h13);
        drive(0, 5'd12, 32'h12);
        tick(); sv = 4'b0;
        tick();
        tests++;
        if (cdb_src !== 2'd1) begin fails++; $display("FAIL rr_ptr_after_wrap: got %0d required 1", cdb_src); end
        tick(); tick();
    endtask

    task automatic test_flush();
        do_reset();
        sv[1] = 1; st[1] = 5'd20; sd[1] = 32'h20;
        sv[3] = 1; st[3] = 5'd21; sd[3] = 32'h21;
        tick();
        sv = 4'b0;
        flush = 1;
        sv[0] = 1; st[0] = 5'd22; sd[0] = 32'h22;
        #1;
        tests++;
        if (sr !== 4'b0000) begin fails++; $display("FAIL flush_ready: got %b required 0000", sr); end
        tick();
        flush = 0; sv = 4'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (cdb_valid !== 1'b0) begin fails++; $display("FAIL flush_write: cycle %0d got %b required 0", i, cdb_valid); end
            tick();
        end
        tests++;
        if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL flush_count: got %0d required 0", conflict_cnt); end
        drive(1, 5'd23, 32'h23);
        drive(2, 5'd24, 32'h24);
        tick(); sv = 4'b0; tick(); tick();
        drive(0, 5'd25, 32'hCAFE0025);
        tick(); sv = 4'b0;
        tick();
        flush = 1;
        #1;
        tests++;
        if (cdb_valid !== 1'b1) begin fails++; $display("FAIL flush_after_grant: got %b required 1", cdb_valid); end
        tick();
        flush = 0;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        free_run = 1;
        for (int s = 0; s < 4; s++) begin sv[s] = 1; st[s] = 5'(s); sd[s] = 32'(s); end
        for (int i = 0; i < 65540; i++) tick();
        tests++;
        if (conflict_cnt !== 16'hFFFF) begin fails++; $display("FAIL cnt_saturate: got %h required ffff", conflict_cnt); end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        tests++;
        if (conflict_cnt !== 16'd0) begin fails++; $display("FAIL cnt_clear: got %h required 0", conflict_cnt); end
        tick();
        tests++;
        if (conflict_cnt !== 16'd1) begin fails++; $display("FAIL cnt_resume: got %h required 1", conflict_cnt); end
        sv = 4'b0;
        rst_n = 0;
        tick();
        free_run = 0;
        rst_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_rr_wrap();
        test_flush();
        test_saturation();
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL sb_drain: got %0d pending required 0", q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
